// File: rtl/memory_interface_if.sv
// Memory-side bus of memory_interface: port A (read/write) and port B (fetch, read-only).
// The controller is the master; the RAM wrapper attaches to the slave modport.
interface memory_interface_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 9
);
  logic              wen_A;
  logic              ren_A;
  logic [ADDR_W-1:0] addr_A;
  logic [DATA_W-1:0] wdata_A;
  logic [DATA_W-1:0] rdata_A;
  logic              ren_B;
  logic [ADDR_W-1:0] addr_B;
  logic [DATA_W-1:0] rdata_B;

  modport master (
    output wen_A, ren_A, addr_A, wdata_A, ren_B, addr_B,
    input  rdata_A, rdata_B
  );

  modport slave (
    input  wen_A, ren_A, addr_A, wdata_A, ren_B, addr_B,
    output rdata_A, rdata_B
  );
endinterface

// File: rtl/memory_interface.sv
// MAR/MDR/PC/MBR register file with a read/write port A and an instruction-fetch port B.
// Optional PC_AUTO_INC_EN: each accepted fetch post-increments PC (ld_pc wins).
module memory_interface #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_mar,
  input  logic [ADDR_W-1:0] mar_in,
  input  logic              ld_mdr,
  input  logic [DATA_W-1:0] mdr_in,
  input  logic              ld_pc,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              rd,
  input  logic              wr,
  input  logic              fetch,
  output logic [DATA_W-1:0] mdr,
  output logic [DATA_W-1:0] mbr,
  output logic [ADDR_W-1:0] pc,
  output logic              busy_a,
  output logic              busy_b,
  output logic              mdr_valid,
  output logic              mbr_valid,
  output logic              collision,
  memory_interface_if.master mem
);

  typedef enum logic {A_IDLE, A_RD}    a_state_t;
  typedef enum logic {B_IDLE, B_FETCH} b_state_t;

  a_state_t a_state_reg, a_state_next;
  b_state_t b_state_reg, b_state_next;

  logic [ADDR_W-1:0] mar_reg;
  logic [DATA_W-1:0] mdr_reg;
  logic [ADDR_W-1:0] pc_reg;
  logic [DATA_W-1:0] mbr_reg;
  logic              mdr_valid_reg;
  logic              mbr_valid_reg;
  logic              collision_reg;

  logic wr_accept;
  logic rd_accept;
  logic fetch_accept;

  // Port A: a write always wins over a simultaneous read; requests while busy are dropped.
  always_comb begin
    a_state_next = a_state_reg;
    wr_accept    = 1'b0;
    rd_accept    = 1'b0;
    case (a_state_reg)
      A_IDLE: begin
        if (!rst) begin
          if (wr) begin
            wr_accept = 1'b1;
          end else if (rd) begin
            rd_accept    = 1'b1;
            a_state_next = A_RD;
          end
        end
      end
      A_RD:    a_state_next = A_IDLE;
      default: a_state_next = A_IDLE;
    endcase
  end

  always_comb begin
    b_state_next = b_state_reg;
    fetch_accept = 1'b0;
    case (b_state_reg)
      B_IDLE: begin
        if (!rst && fetch) begin
          fetch_accept = 1'b1;
          b_state_next = B_FETCH;
        end
      end
      B_FETCH: b_state_next = B_IDLE;
      default: b_state_next = B_IDLE;
    endcase
  end

  assign mem.wen_A   = wr_accept;
  assign mem.ren_A   = rd_accept;
  assign mem.addr_A  = mar_reg;
  assign mem.wdata_A = mdr_reg;
  assign mem.ren_B   = fetch_accept;
  assign mem.addr_B  = pc_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_state_reg   <= A_IDLE;
      b_state_reg   <= B_IDLE;
      mar_reg       <= '0;
      mdr_reg       <= '0;
      pc_reg        <= '0;
      mbr_reg       <= '0;
      mdr_valid_reg <= 1'b0;
      mbr_valid_reg <= 1'b0;
      collision_reg <= 1'b0;
    end else begin
      a_state_reg   <= a_state_next;
      b_state_reg   <= b_state_next;
      mdr_valid_reg <= (a_state_reg == A_RD);
      mbr_valid_reg <= (b_state_reg == B_FETCH);
      collision_reg <= wr_accept && rd;

      if (ld_mar) begin
        mar_reg <= mar_in;
      end

      // The read return takes MDR even if the datapath loads it in the same cycle.
      if (a_state_reg == A_RD) begin
        mdr_reg <= mem.rdata_A;
      end else if (ld_mdr) begin
        mdr_reg <= mdr_in;
      end

      if (b_state_reg == B_FETCH) begin
        mbr_reg <= mem.rdata_B;
      end

`ifdef PC_AUTO_INC_EN
      if (ld_pc) begin
        pc_reg <= pc_in;
      end else if (fetch_accept) begin
        pc_reg <= pc_reg + ADDR_W'(1);
      end
`else
      if (ld_pc) begin
        pc_reg <= pc_in;
      end
`endif
    end
  end

  assign mdr       = mdr_reg;
  assign mbr       = mbr_reg;
  assign pc        = pc_reg;
  assign busy_a    = (a_state_reg == A_RD);
  assign busy_b    = (b_state_reg == B_FETCH);
  assign mdr_valid = mdr_valid_reg;
  assign mbr_valid = mbr_valid_reg;
  assign collision = collision_reg;

endmodule

// File: tb/tb_memory_interface.sv
// Directed bench for memory_interface with a one-cycle-latency RAM model and
// MDR/MBR scoreboards filled when requests are driven and drained on the valid pulses.
module tb_memory_interface;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 9;

  logic              clk = 1'b0;
  logic              rst;
  logic              ld_mar, ld_mdr, ld_pc;
  logic [ADDR_W-1:0] mar_in, pc_in;
  logic [DATA_W-1:0] mdr_in;
  logic              rd, wr, fetch;
  logic [DATA_W-1:0] mdr, mbr;
  logic [ADDR_W-1:0] pc;
  logic              busy_a, busy_b, mdr_valid, mbr_valid, collision;

  memory_interface_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mif ();

  memory_interface #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .ld_mar    (ld_mar),
    .mar_in    (mar_in),
    .ld_mdr    (ld_mdr),
    .mdr_in    (mdr_in),
    .ld_pc     (ld_pc),
    .pc_in     (pc_in),
    .rd        (rd),
    .wr        (wr),
    .fetch     (fetch),
    .mdr       (mdr),
    .mbr       (mbr),
    .pc        (pc),
    .busy_a    (busy_a),
    .busy_b    (busy_b),
    .mdr_valid (mdr_valid),
    .mbr_valid (mbr_valid),
    .collision (collision),
    .mem       (mif.master)
  );

  always #5 clk = ~clk;

  // Unwritten locations return a fixed address-derived pattern.
  function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a);
    return a ^ 9'h0A5;
  endfunction

  logic [DATA_W-1:0] ram [1 << ADDR_W];
  bit                ram_written [1 << ADDR_W];

  always @(posedge clk) begin
    if (mif.wen_A) begin
      ram[mif.addr_A]         <= mif.wdata_A;
      ram_written[mif.addr_A] <= 1'b1;
    end
    if (mif.ren_A) begin
      mif.rdata_A <= ram_written[mif.addr_A] ? ram[mif.addr_A] : pat(mif.addr_A);
    end
    if (mif.ren_B) begin
      mif.rdata_B <= ram_written[mif.addr_B] ? ram[mif.addr_B] : pat(mif.addr_B);
    end
  end

  int checks = 0;
  int errors = 0;
  int ren_a_cnt = 0;
  int mdr_valid_cnt = 0;
  logic [DATA_W-1:0] mdr_q [$];
  logic [DATA_W-1:0] mbr_q [$];
  logic [DATA_W-1:0] exp_val;
  logic [ADDR_W-1:0] exp_pc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Advance one cycle, then drain the scoreboards on any valid pulse.
  task automatic tick();
    if (mif.ren_A) ren_a_cnt++;
    @(posedge clk);
    #1;
    if (mdr_valid) begin
      mdr_valid_cnt++;
      check("mdr_valid_expected", 32'(mdr_q.size() > 0), 32'd1);
      if (mdr_q.size() > 0) begin
        exp_val = mdr_q.pop_front();
        check("mdr_read_data", 32'(mdr), 32'(exp_val));
        $display("read  -> mdr=0x%03h expected 0x%03h", mdr, exp_val);
      end
    end
    if (mbr_valid) begin
      check("mbr_valid_expected", 32'(mbr_q.size() > 0), 32'd1);
      if (mbr_q.size() > 0) begin
        exp_val = mbr_q.pop_front();
        check("mbr_fetch_data", 32'(mbr), 32'(exp_val));
        $display("fetch -> mbr=0x%03h expected 0x%03h", mbr, exp_val);
      end
    end
  endtask

  task automatic idle_inputs();
    ld_mar = 0; ld_mdr = 0; ld_pc = 0;
    rd = 0; wr = 0; fetch = 0;
  endtask

  initial begin
    rst = 1; idle_inputs();
    mar_in = '0; mdr_in = '0; pc_in = '0;
    mif.rdata_A = '0; mif.rdata_B = '0;
    #1;

    // Reset: requests are ignored and strobes held low.
    rd = 1; wr = 1; fetch = 1;
    #1;
    check("rst_wen_A", 32'(mif.wen_A), 0);
    check("rst_ren_A", 32'(mif.ren_A), 0);
    check("rst_ren_B", 32'(mif.ren_B), 0);
    tick(); tick();
    rst = 0; idle_inputs();
    #1;
    check("rst_mdr", 32'(mdr), 0);
    check("rst_mbr", 32'(mbr), 0);
    check("rst_pc", 32'(pc), 0);
    check("rst_flags", {busy_a, busy_b, mdr_valid, mbr_valid, collision}, 0);
    $display("reset -> mdr=0x%03h mbr=0x%03h pc=0x%03h", mdr, mbr, pc);

    // Write 0x1A3 to 0x005, then read it back.
    ld_mar = 1; mar_in = 9'h005; ld_mdr = 1; mdr_in = 9'h1A3;
    tick(); idle_inputs();
    wr = 1;
    #1;
    check("wr_wen_A", 32'(mif.wen_A), 1);
    check("wr_ren_A", 32'(mif.ren_A), 0);
    check("wr_addr_A", 32'(mif.addr_A), 32'h005);
    check("wr_wdata_A", 32'(mif.wdata_A), 32'h1A3);
    $display("write -> addr_A=0x%03h wdata_A=0x%03h", mif.addr_A, mif.wdata_A);
    tick(); idle_inputs();
    rd = 1;
    #1;
    check("rd_ren_A", 32'(mif.ren_A), 1);
    check("rd_addr_A", 32'(mif.addr_A), 32'h005);
    mdr_q.push_back(9'h1A3);
    tick(); idle_inputs();
    #1;
    check("rd_busy_a", 32'(busy_a), 1);
    check("rd_valid_early", 32'(mdr_valid), 0);
    mdr_valid_cnt = 0;
    tick();
    check("rd_valid_pulse", 32'(mdr_valid), 1);
    tick();
    check("rd_valid_once", 32'(mdr_valid_cnt), 1);

    // Collision: write happens, read dropped, collision pulses once.
    ld_mar = 1; mar_in = 9'h007; ld_mdr = 1; mdr_in = 9'h055;
    tick(); idle_inputs();
    rd = 1; wr = 1;
    #1;
    check("col_wen_A", 32'(mif.wen_A), 1);
    check("col_ren_A", 32'(mif.ren_A), 0);
    check("col_addr_A", 32'(mif.addr_A), 32'h007);
    check("col_wdata_A", 32'(mif.wdata_A), 32'h055);
    tick(); idle_inputs();
    #1;
    check("col_pulse", 32'(collision), 1);
    check("col_busy_a", 32'(busy_a), 0);
    $display("collision -> collision=%0b busy_a=%0b", collision, busy_a);
    tick();
    check("col_pulse_end", 32'(collision), 0);
    check("col_mdr_kept", 32'(mdr), 32'h055);
    rd = 1;
    mdr_q.push_back(9'h055);
    tick(); idle_inputs();
    tick(); tick();

    // Back-to-back reads: the second is dropped; ld_mdr during A_RD loses.
    ld_mar = 1; mar_in = 9'h020;
    tick(); idle_inputs();
    ren_a_cnt = 0; mdr_valid_cnt = 0;
    rd = 1;
    #1;
    check("busy_first_ren_A", 32'(mif.ren_A), 1);
    mdr_q.push_back(pat(9'h020));
    tick();
    rd = 1; ld_mdr = 1; mdr_in = 9'h0F0;
    #1;
    check("busy_second_ren_A", 32'(mif.ren_A), 0);
    check("busy_wen_A", 32'(mif.wen_A), 0);
    tick(); idle_inputs();
    #1;
    check("busy_mdr_priority", 32'(mdr), 32'(pat(9'h020)));
    tick(); tick();
    check("busy_ren_count", 32'(ren_a_cnt), 1);
    check("busy_valid_count", 32'(mdr_valid_cnt), 1);

    // Fetch twice from PC=0x1FF.
    ld_pc = 1; pc_in = 9'h1FF;
    tick(); idle_inputs();
    fetch = 1;
    #1;
    check("fetch1_ren_B", 32'(mif.ren_B), 1);
    check("fetch1_addr_B", 32'(mif.addr_B), 32'h1FF);
    mbr_q.push_back(pat(9'h1FF));
    tick(); idle_inputs();
    #1;
    check("fetch1_busy_b", 32'(busy_b), 1);
    tick();
`ifdef PC_AUTO_INC_EN
    exp_pc = 9'h000;
`else
    exp_pc = 9'h1FF;
`endif
    fetch = 1;
    #1;
    check("fetch2_addr_B", 32'(mif.addr_B), 32'(exp_pc));
    $display("fetch -> addr_B=0x%03h expected 0x%03h", mif.addr_B, exp_pc);
    mbr_q.push_back(pat(exp_pc));
    tick(); idle_inputs();
    tick(); tick();
`ifdef PC_AUTO_INC_EN
    exp_pc = 9'h001;
`else
    exp_pc = 9'h1FF;
`endif
    check("fetch_pc_after", 32'(pc), 32'(exp_pc));

    // Reset in the A_RD cycle discards the return.
    ld_mar = 1; mar_in = 9'h030;
    tick(); idle_inputs();
    rd = 1;
    tick(); idle_inputs();
    rst = 1;
    tick();
    rst = 0;
    #1;
    check("rstrd_mdr", 32'(mdr), 0);
    check("rstrd_busy_a", 32'(busy_a), 0);
    check("rstrd_valid", 32'(mdr_valid), 0);
    tick();
    check("rstrd_valid_late", 32'(mdr_valid), 0);

    // Concurrent read and fetch.
    ld_mar = 1; mar_in = 9'h003; ld_pc = 1; pc_in = 9'h004;
    tick(); idle_inputs();
    rd = 1; fetch = 1;
    #1;
    check("conc_ren_A", 32'(mif.ren_A), 1);
    check("conc_ren_B", 32'(mif.ren_B), 1);
    check("conc_addr_A", 32'(mif.addr_A), 32'h003);
    check("conc_addr_B", 32'(mif.addr_B), 32'h004);
    mdr_q.push_back(pat(9'h003));
    mbr_q.push_back(pat(9'h004));
    tick(); idle_inputs();
    tick();
    check("conc_both_valid", {30'd0, mdr_valid, mbr_valid}, 32'd3);

    // Requests use pre-load MAR/PC; ld_pc beats auto-increment.
`ifdef PC_AUTO_INC_EN
    exp_pc = 9'h005;
`else
    exp_pc = 9'h004;
`endif
    rd = 1; ld_mar = 1; mar_in = 9'h040;
    fetch = 1; ld_pc = 1; pc_in = 9'h010;
    #1;
    check("preload_addr_A", 32'(mif.addr_A), 32'h003);
    check("preload_addr_B", 32'(mif.addr_B), 32'(exp_pc));
    mdr_q.push_back(pat(9'h003));
    mbr_q.push_back(pat(exp_pc));
    tick(); idle_inputs();
    #1;
    check("ldpc_priority", 32'(pc), 32'h010);
    tick();
    rd = 1;
    #1;
    check("newmar_addr_A", 32'(mif.addr_A), 32'h040);
    mdr_q.push_back(pat(9'h040));
    tick(); idle_inputs();
    tick(); tick();

    check("mdr_queue_empty", 32'(mdr_q.size()), 0);
    check("mbr_queue_empty", 32'(mbr_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_interface.md
MEMORY_INTERFACE -- requirements
Module: memory_interface

Interface
REQ-001 SHALL have parameter ADDR_W, default 9, address width of both memory ports.
REQ-002 SHALL have parameter DATA_W, default 9, data width of MAR/MDR/PC/MBR and memory data.
REQ-003 SHALL have clock and reset: clk  in  1  single clock, all state updates on rising edge; rst  in  1  reset, synchronous and active-high.
REQ-004 SHALL have datapath-side ports:
- ld_mar  in  1  load MAR from mar_in
- mar_in  in  ADDR_W
- ld_mdr  in  1  load MDR from mdr_in
- mdr_in  in  DATA_W
- ld_pc  in  1  load PC from pc_in
- pc_in  in  ADDR_W
- rd  in  1  word read request
- wr  in  1  word write request
- fetch  in  1  instruction-byte fetch request
- mdr  out  DATA_W
- mbr  out  DATA_W
- pc  out  ADDR_W
- busy_a  out  1  port A read outstanding
- busy_b  out  1  port B fetch outstanding
- mdr_valid  out  1  one-cycle pulse, MDR updated by a read
- mbr_valid  out  1  one-cycle pulse, MBR updated by a fetch
- collision  out  1  one-cycle pulse, rd and wr accepted together
REQ-005 SHALL have memory-side ports:
- wen_A, ren_A  out  1 each
- addr_A  out  ADDR_W
- wdata_A  out  DATA_W
- rdata_A  in  DATA_W
- ren_B  out  1
- addr_B  out  ADDR_W
- rdata_B  in  DATA_W
- Memory read latency is one cycle: rdata valid in the cycle after ren.

Function
REQ-006 MAR, MDR and PC SHALL be registers; ld_* SHALL update them at the clock edge ending the cycle.
REQ-007 Port A FSM SHALL have states A_IDLE and A_RD. Port B FSM SHALL have states B_IDLE and B_FETCH.
REQ-008 In A_IDLE with wr=1, wen_A=1, addr_A=MAR and wdata_A=MDR SHALL be driven combinationally in the same cycle. The FSM SHALL stay in A_IDLE (single-cycle write).
REQ-009 In A_IDLE with rd=1 and wr=0, ren_A=1 and addr_A=MAR SHALL be driven in the same cycle, and the FSM SHALL go to A_RD.
REQ-010 In A_RD, busy_a=1. MDR SHALL take rdata_A at the end of the cycle, and the FSM SHALL return to A_IDLE. mdr_valid SHALL be 1 in the following cycle only. Read request to MDR visible: 2 cycles.
REQ-011 In A_IDLE with rd=1 and wr=1, the write SHALL be performed, the read dropped, and collision pulsed in the next cycle.
REQ-012 rd/wr presented while busy_a=1 SHALL be ignored, with no queuing and no memory strobe.
REQ-013 Fetch SHALL mirror the read: in B_IDLE with fetch=1, ren_B=1 and addr_B=PC in the same cycle, then go to B_FETCH. B_FETCH SHALL have busy_b=1, capture rdata_B into MBR, and pulse mbr_valid next cycle. Fetch while busy_b=1 SHALL be ignored.
REQ-014 Ports A and B SHALL operate independently; a read and a fetch in the same cycle SHALL both proceed.
REQ-015 A request and ld_mar/ld_pc in the same cycle SHALL use the pre-load register value.
REQ-016 ld_mdr in the A_RD cycle SHALL lose to the read return (MDR=rdata_A).
REQ-017 Memory strobes SHALL be 0 whenever not driven per REQ-008/009/013. Addresses and wdata SHALL be don't-care when no strobe is active.
REQ-018 Address arithmetic SHALL wrap modulo 2^ADDR_W.

Reset
REQ-019 rst=1 at an edge SHALL set MAR, MDR, PC and MBR to 0, both FSMs to idle, and busy_*, *_valid and collision to 0.
REQ-020 While rst=1, wen_A, ren_A and ren_B SHALL be 0 and requests SHALL be ignored.
REQ-021 Reset during A_RD/B_FETCH SHALL discard the return: no MDR/MBR update and no valid pulse.

Configuration
REQ-022 With PC_AUTO_INC_EN defined, each accepted fetch SHALL set PC to PC+1 (wrap 511->0) at the end of the accepting cycle. ld_pc in the same cycle SHALL have priority over the increment.
REQ-023 Without PC_AUTO_INC_EN, PC SHALL change only via ld_pc or reset.

Verification
REQ-024 Write/read: ld_mar 0x005, ld_mdr 0x1A3; wr; then rd -> wen_A with addr 0x005 and wdata 0x1A3; 2 cycles later MDR=0x1A3 and mdr_valid pulses once.
REQ-025 Collision: rd=wr=1 with MAR=0x007 and MDR=0x055 -> single write, no ren_A, collision=1 for one cycle, MDR unchanged.
REQ-026 Busy drop: rd on consecutive cycles -> exactly one ren_A and one mdr_valid.
REQ-027 Fetch with PC_AUTO_INC_EN: PC=0x1FF, fetch twice (non-busy) -> addr_B 0x1FF then 0x000. Without the macro, both fetches use 0x1FF.
REQ-028 Reset mid-read: rd, then rst=1 in the A_RD cycle -> MDR=0, no mdr_valid, busy_a=0.
REQ-029 Concurrent: rd (MAR=0x003) and fetch (PC=0x004) in the same cycle -> ren_A and ren_B both high; MDR and MBR update in the same cycle.
